// File: rtl/accumulator_pkg.sv
// accumulator_pkg: types and helpers shared by the accumulator buffer and its drain.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package accumulator_pkg;

    // Element width code: element width = SEW << code; BW_RSVD is rejected at start.
    typedef enum logic [1:0] {
        BW_1X   = 2'd0,
        BW_2X   = 2'd1,
        BW_4X   = 2'd2,
        BW_RSVD = 2'd3
    } bitwidth_e;

    // Drain sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } drain_state_e;

    // log2 of the element width multiple; also the right-shift that turns the
    // buffer depth into the element count of a tile.
    function automatic logic [1:0] elem_shift(input bitwidth_e bw);
        logic [1:0] sh;
        case (bw)
            BW_1X:   sh = 2'd0;
            BW_2X:   sh = 2'd1;
            BW_4X:   sh = 2'd2;
            default: sh = 2'd0;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/accumulator_drain_element_unpack.sv
// element_unpack: slices the low (SEW << bitwidth) bits of a buffer word and sign-extends them to 4*SEW.
// Latency: purely combinational.
// Backpressure: none; the caller registers the result. ACCUMULATOR_DRAIN_RELU_EN clamps negative results to 0.
module element_unpack
    import accumulator_pkg::*;
#(
    parameter int SEW = 4,
    localparam int EW = 4 * SEW
) (
    input  bitwidth_e        bitwidth,
    input  logic [EW-1:0]    raw,
    output logic [EW-1:0]    elem
);

    logic [EW-1:0] ext;

    // Sign-extend the selected slice; unused upper bits of the word are ignored.
    always_comb begin
        ext = '0;
        case (bitwidth)
            BW_1X:   ext = {{(EW - SEW){raw[SEW-1]}}, raw[SEW-1:0]};
            BW_2X:   ext = {{(EW - 2*SEW){raw[2*SEW-1]}}, raw[2*SEW-1:0]};
            default: ext = raw;
        endcase
    end

    // Optional ReLU on the already sign-extended value, same cycle.
    always_comb begin
`ifdef ACCUMULATOR_DRAIN_RELU_EN
        elem = ext[EW-1] ? '0 : ext;
`else
        elem = ext;
`endif
    end

endmodule

// File: rtl/accumulator_drain.sv
// accumulator_drain: streams a finished tile out of the accumulator buffer as sign-extended elements, then pulses buffer_transfer.
// Latency: start sampled at edge k -> element 0 valid in cycle k+2; with out_ready high, DONE in cycle k+N+2.
// Backpressure: out_ready low holds out_data/out_index/read pointer; every stall cycle delays all later events by one.
// Build option: ACCUMULATOR_DRAIN_RELU_EN outputs negative elements as 0 (applied in element_unpack).
module accumulator_drain
    import accumulator_pkg::*;
#(
    parameter int BUFFER_WIDTH           = 8,
    parameter int SMALLEST_ELEMENT_WIDTH = 4,
    localparam int EW = 4 * SMALLEST_ELEMENT_WIDTH,
    localparam int IW = $clog2(BUFFER_WIDTH),
    localparam int PW = IW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    bitwidth,
    output logic [IW-1:0] buffer_bank_entry,
    input  logic [EW-1:0] buffer_data_read,
    output logic          buffer_transfer,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [EW-1:0] out_data,
    output logic [IW-1:0] out_index,
    output logic          busy,
    output logic          done,
    output logic          error
);

    drain_state_e  state_q;
    drain_state_e  state_d;
    bitwidth_e     bw_q;
    logic [PW-1:0] ptr_q;       // one bit wider than the index so it can reach N
    logic [PW-1:0] n_elems;
    logic          start_ok;
    logic          start_bad;
    logic          load;
    logic          handshake;
    logic          error_q;
    logic [EW-1:0] unpacked;

    // start is only honoured in IDLE; the reserved width code is refused there.
    assign start_ok  = (state_q == ST_IDLE) && start && (bitwidth != BW_RSVD);
    assign start_bad = (state_q == ST_IDLE) && start && (bitwidth == BW_RSVD);

    // Element count of the tile for the latched width.
    assign n_elems   = PW'(BUFFER_WIDTH >> elem_shift(bw_q));
    assign handshake = out_valid && out_ready;

    element_unpack #(
        .SEW (SMALLEST_ELEMENT_WIDTH)
    ) u_unpack (
        .bitwidth (bw_q),
        .raw      (buffer_data_read),
        .elem     (unpacked)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, load strobe and status outputs.
    always_comb begin
        state_d           = state_q;
        load              = 1'b0;
        busy              = 1'b0;
        done              = 1'b0;
        buffer_transfer   = 1'b0;
        buffer_bank_entry = '0;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy              = 1'b1;
                buffer_bank_entry = ptr_q[IW-1:0];
                // Fetch the next word whenever the output register is free or emptying.
                load              = (!out_valid || out_ready) && (ptr_q < n_elems);
                // Last element is leaving (or already gone): finish next cycle.
                if ((ptr_q == n_elems) && (!out_valid || out_ready)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy            = 1'b1;
                done            = 1'b1;
                buffer_transfer = 1'b1;
                state_d         = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Latch the width at start and advance the read pointer on every load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
            bw_q  <= BW_1X;
        end else if (start_ok) begin
            ptr_q <= '0;
            bw_q  <= bitwidth_e'(bitwidth);
        end else if (load) begin
            ptr_q <= ptr_q + PW'(1);
        end
    end

    // Output register: load wins over handshake, holds while stalled, empty in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
        end else if (state_q == ST_DONE) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= unpacked;
            out_index <= ptr_q[IW-1:0];
        end else if (handshake) begin
            out_valid <= 1'b0;
        end
    end

    // Rejected start reports one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= start_bad;
        end
    end

    assign error = error_q;

endmodule
